// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding and the iteration-counter width helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must reach WIDTH-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface seq_mult_ctrl_if #(
   parameter int WIDTH = 8
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (output start, a, b, input busy, done, product);
   modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-and-add datapath: operand magnitudes, running accumulator and step counter.
// Signed operands are multiplied as magnitudes; the sign is reapplied by the controller.
module seq_mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SIGNED     = 0,
   parameter int EARLY_TERM = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_nxt_o,
   output logic               neg_o,
   output logic               last_step_o
);
   localparam int CNT_W = cnt_width(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   a_mag, b_mag;

   // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
   always_comb begin
      a_mag = a_i;
      b_mag = b_i;
      if (SIGNED != 0 && a_i[WIDTH-1]) a_mag = -a_i;
      if (SIGNED != 0 && b_i[WIDTH-1]) b_mag = -b_i;
   end

   assign acc_nxt_o   = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign neg_o       = neg_q;
   assign last_step_o = (cnt_q == CNT_W'(WIDTH-1)) ||
                        ((EARLY_TERM != 0) && (mplier_q[WIDTH-1:1] == '0));

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      if (load_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_mag};
         mplier_d = b_mag;
         acc_d    = '0;
         cnt_d    = '0;
         neg_d    = (SIGNED != 0) && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      end else if (step_i) begin
         acc_d    = acc_nxt_o;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
      end
   end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential multiplier top: IDLE/CALC/DONE controller, busy/done decode and
// the product register, which holds until the next operation completes.
module seq_mult_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SIGNED     = 0,
   parameter int EARLY_TERM = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   seq_mult_ctrl_if.slave bus
);
   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               load, step, last_step, neg;
   logic [2*WIDTH-1:0] acc_nxt;

   seq_mult_datapath #(
      .WIDTH      (WIDTH),
      .SIGNED     (SIGNED),
      .EARLY_TERM (EARLY_TERM)
   ) u_dp (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .step_i      (step),
      .a_i         (bus.a),
      .b_i         (bus.b),
      .acc_nxt_o   (acc_nxt),
      .neg_o       (neg),
      .last_step_o (last_step)
   );

   assign step = (state_q == CALC);

   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      load      = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            load    = 1'b1;
            state_d = CALC;
         end
         CALC: if (last_step) begin
            product_d = neg ? -acc_nxt : acc_nxt;
            state_d   = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
      end
   end

   // Straight decodes of the state flop, so no combinational glitches.
   assign bus.busy    = (state_q == CALC);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: three 8-bit configurations (unsigned,
// unsigned with early termination, signed) driven from a vector table plus hand sequences.
module tb_seq_mult_ctrl;

   logic clk;
   logic rst_n;

   seq_mult_ctrl_if #(.WIDTH(8)) if0 ();
   seq_mult_ctrl_if #(.WIDTH(8)) if1 ();
   seq_mult_ctrl_if #(.WIDTH(8)) if2 ();

   seq_mult_ctrl #(.WIDTH(8), .SIGNED(0), .EARLY_TERM(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   seq_mult_ctrl #(.WIDTH(8), .SIGNED(0), .EARLY_TERM(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   seq_mult_ctrl #(.WIDTH(8), .SIGNED(1), .EARLY_TERM(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp_p;
      int          exp_calc;
      string       name;
   } vec_t;

   vec_t vecs[14];
   int   total = 0;
   int   passed = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic set_ab(input int idx, input logic [7:0] a, input logic [7:0] b);
      case (idx)
         0: begin if0.a = a; if0.b = b; end
         1: begin if1.a = a; if1.b = b; end
         default: begin if2.a = a; if2.b = b; end
      endcase
   endtask

   task automatic set_start(input int idx, input logic s);
      case (idx)
         0: if0.start = s;
         1: if1.start = s;
         default: if2.start = s;
      endcase
   endtask

   function automatic logic get_busy(input int idx);
      case (idx)
         0: return if0.busy;
         1: return if1.busy;
         default: return if2.busy;
      endcase
   endfunction

   function automatic logic get_done(input int idx);
      case (idx)
         0: return if0.done;
         1: return if1.done;
         default: return if2.done;
      endcase
   endfunction

   function automatic logic [15:0] get_prod(input int idx);
      case (idx)
         0: return if0.product;
         1: return if1.product;
         default: return if2.product;
      endcase
   endfunction

   // Called #1 after the accept edge (cycle 1). Returns at the cycle after done.
   task automatic monitor(input int idx, input bit scramble,
                          output int busy_cnt, output int done_cyc, output int done_cnt);
      busy_cnt = 0;
      done_cyc = 0;
      done_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         if (get_busy(idx)) busy_cnt++;
         if (get_done(idx)) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (done_cyc != 0 && c == done_cyc + 1) break;
         if (scramble) set_ab(idx, 8'(c * 37 + 1), 8'(c * 53 + 2));
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         output int busy_cnt, output int done_cyc, output int done_cnt);
      @(negedge clk);
      set_ab(idx, a, b);
      set_start(idx, 1'b1);
      @(posedge clk); #1;
      set_start(idx, 1'b0);
      monitor(idx, 1'b0, busy_cnt, done_cyc, done_cnt);
   endtask

   initial begin
      int bc, dc, dn;
      bit saw_done;

      vecs[0]  = '{0, 8'd255, 8'd255, 16'hFE01, 8, "u_255x255"};
      vecs[1]  = '{0, 8'd77,  8'd0,   16'd0,    8, "u_77x0"};
      vecs[2]  = '{0, 8'd1,   8'd200, 16'd200,  8, "u_1x200"};
      vecs[3]  = '{1, 8'd200, 8'd3,   16'd600,  2, "et_200x3"};
      vecs[4]  = '{1, 8'd200, 8'd0,   16'd0,    1, "et_200x0"};
      vecs[5]  = '{1, 8'd7,   8'd1,   16'd7,    1, "et_7x1"};
      vecs[6]  = '{1, 8'd5,   8'h80,  16'd640,  8, "et_5x128"};
      vecs[7]  = '{1, 8'd9,   8'h10,  16'd144,  5, "et_9x16"};
      vecs[8]  = '{1, 8'd200, 8'hFF,  16'd51000, 8, "et_200x255"};
      vecs[9]  = '{2, 8'hF9,  8'd6,   16'hFFD6, 8, "s_m7x6"};
      vecs[10] = '{2, 8'h80,  8'h80,  16'h4000, 8, "s_m128xm128"};
      vecs[11] = '{2, 8'h80,  8'h01,  16'hFF80, 8, "s_m128x1"};
      vecs[12] = '{2, 8'h05,  8'hFD,  16'hFFF1, 8, "s_5xm3"};
      vecs[13] = '{2, 8'h7F,  8'h7F,  16'h3F01, 8, "s_127x127"};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_start(i, 1'b0);
         set_ab(i, 8'd0, 8'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_busy%0d", i), get_busy(i), 0);
         chk($sformatf("reset_done%0d", i), get_done(i), 0);
         chk($sformatf("reset_prod%0d", i), get_prod(i), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Basic unsigned op, then product must hold through IDLE.
      run_op(0, 8'd13, 8'd11, bc, dc, dn);
      chk("t1_busy_cycles", bc, 8);
      chk("t1_done_cycle", dc, 9);
      chk("t1_done_pulses", dn, 1);
      chk("t1_product", get_prod(0), 143);
      repeat (5) @(posedge clk);
      #1;
      chk("t1_product_hold", get_prod(0), 143);

      foreach (vecs[i]) begin
         run_op(vecs[i].idx, vecs[i].a, vecs[i].b, bc, dc, dn);
         chk({vecs[i].name, "_product"}, get_prod(vecs[i].idx), vecs[i].exp_p);
         chk({vecs[i].name, "_busy_cycles"}, bc, vecs[i].exp_calc);
         chk({vecs[i].name, "_done_cycle"}, dc, vecs[i].exp_calc + 1);
         chk({vecs[i].name, "_done_pulses"}, dn, 1);
      end

      // start held high, operands scrambled after capture.
      @(negedge clk);
      set_ab(0, 8'd6, 8'd7);
      set_start(0, 1'b1);
      @(posedge clk); #1;
      monitor(0, 1'b1, bc, dc, dn);
      chk("t5_product", get_prod(0), 42);
      chk("t5_done_cycle", dc, 9);
      chk("t5_no_accept_in_done", get_busy(0), 0);
      set_ab(0, 8'd2, 8'd3);
      @(posedge clk); #1;
      monitor(0, 1'b0, bc, dc, dn);
      set_start(0, 1'b0);
      chk("t5_second_busy", bc, 8);
      chk("t5_second_done_cycle", dc, 9);
      chk("t5_second_product", get_prod(0), 6);

      // Asynchronous reset in cycle 4 of an operation.
      @(negedge clk);
      set_ab(0, 8'd13, 8'd11);
      set_start(0, 1'b1);
      @(posedge clk); #1;
      set_start(0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      chk("t6_busy_before_rst", get_busy(0), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", get_busy(0), 0);
      chk("t6_rst_done", get_done(0), 0);
      chk("t6_rst_product", get_prod(0), 0);
      chk("t6_rst_product_s", get_prod(2), 0);
      saw_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (get_done(0)) saw_done = 1'b1;
      end
      chk("t6_no_done_in_reset", saw_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 8'd3, 8'd5, bc, dc, dn);
      chk("t6_after_rst_product", get_prod(0), 15);
      chk("t6_after_rst_done_cycle", dc, 9);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
